// File: rtl/ctrl_pkg.sv
// Shared definitions for the control subsystem: 2 MHz read-side FSM encoding,
// default RAM sizing, and the 50 MHz control-side clock constants.
package ctrl_pkg;

  localparam int RAM_DEPTH_DEF = 2048;

  localparam int CLK50_HZ  = 50_000_000;
  localparam int CLK2_HZ   = 2_000_000;
  localparam int CLK_RATIO = CLK50_HZ / CLK2_HZ;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RD   = 2'b01,
    ACC  = 2'b10,
    WR   = 2'b11
  } state_t;

endpackage

// File: rtl/avg4_acc.sv
// Four-byte accumulator; the average is the sum with its two LSBs dropped.
module avg4_acc (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clear,
  input  logic       add_en,
  input  logic [7:0] din,
  output logic [7:0] avg
);

  // 10 bits hold 4 x 255 = 1020 without overflow.
  logic [9:0] acc;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (add_en) begin
      acc <= acc + {2'b00, din};
    end
  end

  assign avg = acc[9:2];

endmodule

// File: rtl/ctrl_blk_2.sv
// Pulls bytes from a FIFO, averages each group of four and writes the result
// to RAM at a descending, wrapping address.
module ctrl_blk_2
  import ctrl_pkg::*;
#(
  parameter int RAM_DEPTH = RAM_DEPTH_DEF,
  parameter int ADDR_W    = 11
) (
  input  logic              clk_2,
  input  logic              reset_n,
  input  logic              empty,
  input  logic [7:0]        fifo_data,
  output logic              rd_fifo,
  output logic              ram_wr_n,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_data,
  output state_t            fsm_state
);

  // FIFO handshake: empty is only looked at in IDLE; rd_fifo is a one-cycle
  // strobe and fifo_data is consumed on the following cycle (ACC).
  state_t            state, state_nxt;
  logic [1:0]        byte_cnt;
  logic [ADDR_W-1:0] addr;

  always_ff @(posedge clk_2) begin
    if (!reset_n) begin
      state    <= IDLE;
      byte_cnt <= '0;
      addr     <= ADDR_W'(RAM_DEPTH - 1);
    end else begin
      state <= state_nxt;
      if (state == ACC) byte_cnt <= byte_cnt + 2'd1;
      if (state == WR) begin
        byte_cnt <= '0;
        // RAM_DEPTH is a power of two, so 0 - 1 wraps to RAM_DEPTH-1.
        addr <= addr - ADDR_W'(1);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!empty) state_nxt = RD;
      RD:      state_nxt = ACC;
      ACC:     state_nxt = (byte_cnt == 2'd3) ? WR : IDLE;
      WR:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  avg4_acc u_avg (
    .clk     (clk_2),
    .reset_n (reset_n),
    .clear   (state == WR),
    .add_en  (state == ACC),
    .din     (fifo_data),
    .avg     (ram_data)
  );

  assign rd_fifo   = (state == RD);
  assign ram_wr_n  = (state != WR);
  assign ram_addr  = addr;
  assign fsm_state = state;

endmodule
